// File: rtl/calc_sequencer.sv
// calc_sequencer: calculator key sequencer FSM issuing registered datapath and memory strobes
module calc_sequencer #(
  parameter int DIGITS = 4,
  parameter int TIMEOUT = 64,
  localparam int CW = $clog2(DIGITS + 1)
) (
  input  logic          clock,
  input  logic          reset_in,
  input  logic          dig_in,
  input  logic          op_in,
  input  logic          ex_in,
  input  logic          clr_in,
  input  logic          bksp_in,
  input  logic          ms_in,
  input  logic          mr_in,
  input  logic          mc_in,
  input  logic          alu_done,
  input  logic          alu_err,
  output logic          load_A,
  output logic          load_B,
  output logic          bksp_A,
  output logic          bksp_B,
  output logic          load_op,
  output logic          load_res_A,
  output logic          clear_regs,
  output logic          alu_start,
  output logic          mem_store,
  output logic          mem_recall_A,
  output logic          mem_recall_B,
  output logic          mem_clear,
  output logic          mem_valid,
  output logic [1:0]    display_select,
  output logic [CW-1:0] digits_A,
  output logic [CW-1:0] digits_B
);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] DMAX = CW'(DIGITS);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  typedef enum logic [2:0] {ENTER_A, OPERATOR, ENTER_B, EXEC, RESULT, ERROR} state_t;
  typedef enum logic [3:0] {K_NONE, K_CLR, K_EX, K_OP, K_BKSP, K_DIG, K_MR, K_MS, K_MC} key_t;
  typedef struct packed {
    logic load_a, load_b, bksp_a, bksp_b, load_op, load_res_a, clear_regs, alu_start;
    logic mem_store, mem_recall_a, mem_recall_b, mem_clear;
  } strobe_t;
  state_t state, state_n;
  key_t key;
  strobe_t st, st_n;
  logic [CW-1:0] da_n, db_n;
  logic [TW-1:0] timer, timer_n;
  logic mv_n;
  logic [1:0] ds_n;
  assign key = clr_in ? K_CLR : ex_in ? K_EX : op_in ? K_OP : bksp_in ? K_BKSP :
               dig_in ? K_DIG : mr_in ? K_MR : ms_in ? K_MS : mc_in ? K_MC : K_NONE;
  assign {load_A, load_B, bksp_A, bksp_B, load_op, load_res_A, clear_regs, alu_start,
          mem_store, mem_recall_A, mem_recall_B, mem_clear} = st;
  assign ds_n = state_n == RESULT ? 2'd2 : state_n == ERROR ? 2'd3 :
                (state_n == ENTER_B || state_n == EXEC) ? 2'd1 : 2'd0;
  always_ff @(posedge clock or posedge reset_in)
    if (reset_in) begin
      state <= ENTER_A;
      st <= '0;
      digits_A <= '0;
      digits_B <= '0;
      mem_valid <= 1'b0;
      display_select <= 2'd0;
      timer <= '0;
    end else begin
      state <= state_n;
      st <= st_n;
      digits_A <= da_n;
      digits_B <= db_n;
      mem_valid <= mv_n;
      display_select <= ds_n;
      timer <= timer_n;
    end
  always_comb begin
    state_n = state;
    if (key == K_CLR) state_n = ENTER_A;
    else case (state)
      ENTER_A: state_n = key == K_OP ? OPERATOR : ENTER_A;
      OPERATOR: state_n = (key == K_DIG || (key == K_MR && mem_valid)) ? ENTER_B : OPERATOR;
      ENTER_B: state_n = key == K_EX ? EXEC : (key == K_BKSP && digits_B == '0) ? OPERATOR : ENTER_B;
      EXEC: state_n = alu_done ? (alu_err ? ERROR : RESULT) : timer == TLAST ? ERROR : EXEC;
      RESULT: state_n = key == K_EX ? EXEC : key == K_OP ? OPERATOR :
                        (key == K_DIG || (key == K_MR && mem_valid)) ? ENTER_A : RESULT;
      default: state_n = state;
    endcase
  end
  always_comb begin
    st_n = '0;
    da_n = digits_A;
    db_n = digits_B;
    mv_n = mem_valid;
    timer_n = state == EXEC ? timer + TW'(1) : timer;
    if (key == K_CLR) begin
      st_n.clear_regs = 1'b1;
      da_n = '0;
      db_n = '0;
      timer_n = '0;
    end else if (state != EXEC && state != ERROR) case (key)
      K_EX: if (state == ENTER_B || state == RESULT) begin
        st_n.alu_start = 1'b1;
        timer_n = '0;
      end
      K_OP: if (state != ENTER_B) begin
        st_n.load_op = 1'b1;
        if (state == RESULT) begin
          st_n.load_res_a = 1'b1;
          da_n = DMAX;
          db_n = '0;
        end
      end
      K_BKSP: if (state == ENTER_A && digits_A != '0) begin
        st_n.bksp_a = 1'b1;
        da_n = digits_A - ONE;
      end else if (state == ENTER_B && digits_B != '0) begin
        st_n.bksp_b = 1'b1;
        db_n = digits_B - ONE;
      end
      K_DIG: if (state == ENTER_A && digits_A != DMAX) begin
        st_n.load_a = 1'b1;
        da_n = digits_A + ONE;
      end else if (state == OPERATOR) begin
        st_n.load_b = 1'b1;
        db_n = ONE;
      end else if (state == ENTER_B && digits_B != DMAX) begin
        st_n.load_b = 1'b1;
        db_n = digits_B + ONE;
      end else if (state == RESULT) begin
        st_n.clear_regs = 1'b1;
        st_n.load_a = 1'b1;
        da_n = ONE;
        db_n = '0;
      end
      K_MR: if (mem_valid) begin
        if (state == ENTER_A) begin
          st_n.mem_recall_a = 1'b1;
          da_n = DMAX;
        end else if (state == RESULT) begin
          st_n.clear_regs = 1'b1;
          st_n.mem_recall_a = 1'b1;
          da_n = DMAX;
          db_n = '0;
        end else begin
          st_n.mem_recall_b = 1'b1;
          db_n = DMAX;
        end
      end
      K_MS: if (state != OPERATOR) begin
        st_n.mem_store = 1'b1;
        mv_n = 1'b1;
      end
      K_MC: begin
        st_n.mem_clear = 1'b1;
        mv_n = 1'b0;
      end
      default: ;
    endcase
  end
endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 SHALL have parameter DIGITS, default 4, maximum digits per operand (1..15).
REQ-002 SHALL have parameter TIMEOUT, default 64, maximum EXEC cycles awaiting alu_done (2..1023).
REQ-003 SHALL have derived localparam CW = clog2(DIGITS+1), the digit-count width.
REQ-004 SHALL have one clock; reset is asynchronous and active-high; ports named clock and reset_in.
REQ-005 Ports: clock in 1 system clock; reset_in in 1 async active-high reset.
REQ-006 Ports: dig_in, op_in, ex_in, clr_in, bksp_in, ms_in, mr_in, mc_in in 1 each: one-cycle key pulses.
REQ-007 Ports: alu_done in 1 ALU result valid; alu_err in 1 ALU error, qualified by alu_done.
REQ-008 Ports: load_A, load_B, bksp_A, bksp_B, load_op, load_res_A, clear_regs, alu_start out 1 each: datapath strobes.
REQ-009 Ports: mem_store, mem_recall_A, mem_recall_B, mem_clear out 1 each: memory strobes; mem_valid out 1: memory holds a value.
REQ-010 Ports: display_select out 2 (0=A, 1=B, 2=result, 3=error); digits_A, digits_B out CW: digits entered.

Function
REQ-011 SHALL register every output; a strobe is high for exactly the one cycle after the input is sampled (latency 1).
REQ-012 SHALL act on at most one input per cycle, priority clr > ex > op > bksp > dig > mr > ms > mc; lower inputs that cycle are dropped.
REQ-013 SHALL implement states ENTER_A, OPERATOR, ENTER_B, EXEC, RESULT, ERROR; display_select = 0,0,1,1,2,3 respectively.
REQ-014 clr_in in any state SHALL pulse clear_regs, zero digits_A/B and the timer, and go to ENTER_A; mem_valid unchanged.
REQ-015 ENTER_A: dig_in with digits_A<DIGITS -> load_A, digits_A+1; at DIGITS ignored.
REQ-016 ENTER_A: bksp_in with digits_A>0 -> bksp_A, digits_A-1; at 0 ignored.
REQ-017 ENTER_A: op_in -> load_op, go OPERATOR (empty A is legal, value 0).
REQ-018 OPERATOR: op_in -> load_op again (operator replaced); bksp_in, ex_in ignored.
REQ-019 OPERATOR: dig_in -> load_B, digits_B=1, go ENTER_B.
REQ-020 ENTER_B: dig_in/bksp_in as REQ-015/016 using load_B/bksp_B/digits_B.
REQ-021 ENTER_B: bksp_in at digits_B=0 -> go OPERATOR; op_in ignored.
REQ-022 ENTER_B: ex_in -> alu_start, timer=0, go EXEC.
REQ-023 EXEC: all inputs except clr_in ignored; timer increments each cycle.
REQ-024 EXEC: alu_done & !alu_err -> RESULT; alu_done & alu_err -> ERROR.
REQ-025 EXEC: timer reaching TIMEOUT without alu_done -> ERROR; alu_done in that same cycle wins.
REQ-026 RESULT: op_in -> load_res_A and load_op same cycle, digits_A=DIGITS, digits_B=0, go OPERATOR (chaining).
REQ-027 RESULT: dig_in -> clear_regs and load_A same cycle (datapath applies clear first), digits_A=1, digits_B=0, go ENTER_A.
REQ-028 RESULT: ex_in -> alu_start, go EXEC (repeat last op on result; datapath contract).
REQ-029 ERROR: only clr_in acts; all else ignored.
REQ-030 ms_in in ENTER_A, ENTER_B or RESULT -> mem_store (datapath stores displayed value), mem_valid=1; else ignored.
REQ-031 mr_in with mem_valid=1: ENTER_A -> mem_recall_A, digits_A=DIGITS; OPERATOR/ENTER_B -> mem_recall_B, digits_B=DIGITS, go ENTER_B.
REQ-032 mr_in with mem_valid=1 in RESULT -> clear_regs and mem_recall_A, digits_A=DIGITS, go ENTER_A.
REQ-033 mr_in with mem_valid=0, or in EXEC/ERROR, SHALL be ignored.
REQ-034 mc_in in any state but EXEC/ERROR -> mem_clear, mem_valid=0.

Reset
REQ-035 reset_in high SHALL immediately force ENTER_A, all strobes 0, digits_A=digits_B=0, mem_valid=0, display_select=0, timer=0.
REQ-036 Reset asserted mid-EXEC SHALL abandon the operation; a later alu_done in ENTER_A is ignored.

Verification
REQ-037 Reset, 5 dig_in (DIGITS=4) -> 4 load_A pulses, digits_A=4, fifth ignored.
REQ-038 dig,dig,op,dig,ex, alu_done 3 cycles later -> load_op once, alu_start once, display_select 0,1,2 sequence, state RESULT.
REQ-039 EXEC with no alu_done, TIMEOUT=8 -> ERROR after 8 cycles, display_select=3; only clr_in exits, with clear_regs.
REQ-040 RESULT, ms_in, clr_in, dig, op, mr_in -> mem_valid stays 1 through clr, mem_recall_B, digits_B=4, state ENTER_B.
REQ-041 op_in and dig_in same cycle in ENTER_A -> only load_op; RESULT then op_in -> load_res_A and load_op together.
REQ-042 reset_in pulse mid-EXEC and mid-ENTER_B -> all outputs 0 asynchronously, mem_valid=0.
